// File: rtl/window_bus_controller.sv
// Decodes CPU bus requests against a programmable window table and sequences one target access at a time.
// A miss responds 2 cycles after accept; a hit responds 2 cycles plus the number of ACCESS cycles. RespValid has no back-pressure.
module window_bus_controller #(
  parameter int WINDOWS = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   CfgWrite,
  input  logic [2:0]             CfgIndex,
  input  logic [1:0]             CfgField,
  input  logic [15:0]            CfgData,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic                   ReqWrite,
  input  logic [15:0]            ReqAddress,
  input  logic [7:0]             ReqWData,
  output logic                   RespValid,
  output logic [7:0]             RespRData,
  output logic                   RespError,
  output logic                   TgtValid,
  output logic [WINDOWS-1:0]     TgtSel,
  output logic                   TgtWrite,
  output logic [15:0]            TgtOffset,
  output logic [7:0]             TgtWData,
  input  logic [WINDOWS-1:0]     TgtAck,
  input  logic [8*WINDOWS-1:0]   TgtRData
);
  typedef enum logic [1:0] {IDLE, DECODE, ACCESS, RESPOND} state_t;
  state_t state, state_nxt;

  logic [15:0]        base [WINDOWS];
  logic [15:0]        head [WINDOWS];
  logic [WINDOWS-1:0] enable;

  logic               req_write;
  logic [15:0]        req_addr;
  logic [7:0]         req_wdata;
  logic [WINDOWS-1:0] sel;
  logic [15:0]        offset;
  logic [7:0]         count;
  logic               resp_error;
  logic [7:0]         resp_rdata;

  logic               hit;
  logic [WINDOWS-1:0] hit_sel;
  logic [15:0]        hit_base;
  logic               ack;
  logic [7:0]         ack_rdata;
  logic               expired;

  // Ascending scan so the lowest matching index wins; Base >= Head can never satisfy both bounds.
  always_comb begin
    hit      = 1'b0;
    hit_sel  = '0;
    hit_base = '0;
    for (int i = 0; i < WINDOWS; i++) begin
      if (!hit && enable[i] && req_addr >= base[i] && req_addr < head[i]) begin
        hit      = 1'b1;
        hit_sel  = WINDOWS'(1) << i;
        hit_base = base[i];
      end
    end
  end

  always_comb begin
    ack_rdata = '0;
    for (int i = 0; i < WINDOWS; i++) begin
      if (sel[i]) ack_rdata = TgtRData[8*i +: 8];
    end
  end

  assign ack     = |(TgtAck & sel);
  assign expired = (count + 8'd1) == 8'(TIMEOUT);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Target strobes are decoded from state so an asynchronous reset drops them without an edge.
  always_comb begin
    state_nxt = state;
    ReqReady  = 1'b0;
    TgtValid  = 1'b0;
    TgtSel    = '0;
    RespValid = 1'b0;
    RespError = 1'b0;
    case (state)
      IDLE: begin
        ReqReady = !Reset;
        if (ReqValid) state_nxt = DECODE;
      end
      DECODE: state_nxt = hit ? ACCESS : RESPOND;
      ACCESS: begin
        TgtValid = 1'b1;
        TgtSel   = sel;
        if (ack || expired) state_nxt = RESPOND;
      end
      RESPOND: begin
        RespValid = 1'b1;
        RespError = resp_error;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < WINDOWS; i++) begin
        base[i] <= '0;
        head[i] <= '0;
      end
      enable     <= '0;
      req_write  <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      sel        <= '0;
      offset     <= '0;
      count      <= '0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
    end else begin
      for (int i = 0; i < WINDOWS; i++) begin
        if (CfgWrite && CfgIndex == 3'(i)) begin
          case (CfgField)
            2'd0:    base[i]   <= CfgData;
            2'd1:    head[i]   <= CfgData;
            2'd2:    enable[i] <= CfgData[0];
            default: ;
          endcase
        end
      end
      case (state)
        IDLE: begin
          if (ReqValid) begin
            req_write <= ReqWrite;
            req_addr  <= ReqAddress;
            req_wdata <= ReqWData;
          end
        end
        DECODE: begin
          count <= '0;
          if (hit) begin
            sel    <= hit_sel;
            offset <= req_addr - hit_base;
          end else begin
            resp_error <= 1'b1;
            resp_rdata <= 8'hFF;
          end
        end
        ACCESS: begin
          if (ack) begin
            resp_error <= 1'b0;
            resp_rdata <= req_write ? 8'h00 : ack_rdata;
          end else if (expired) begin
            resp_error <= 1'b1;
            resp_rdata <= 8'hFF;
          end else begin
            count <= count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign RespRData = resp_rdata;
  assign TgtWrite  = req_write;
  assign TgtOffset = offset;
  assign TgtWData  = req_wdata;
endmodule

// File: tb/tb_window_bus_controller.sv
// Directed bench for window_bus_controller: window decode, latency, timeout, stray acks, config and reset interactions.
module tb_window_bus_controller;
  localparam int W = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          CfgWrite;
  logic [2:0]    CfgIndex;
  logic [1:0]    CfgField;
  logic [15:0]   CfgData;
  logic          ReqValid;
  logic          ReqReady;
  logic          ReqWrite;
  logic [15:0]   ReqAddress;
  logic [7:0]    ReqWData;
  logic          RespValid;
  logic [7:0]    RespRData;
  logic          RespError;
  logic          TgtValid;
  logic [W-1:0]  TgtSel;
  logic          TgtWrite;
  logic [15:0]   TgtOffset;
  logic [7:0]    TgtWData;
  logic [W-1:0]  TgtAck;
  logic [8*W-1:0] TgtRData;

  window_bus_controller #(.WINDOWS(W), .TIMEOUT(15)) dut (
    .Clock(Clock), .Reset(Reset),
    .CfgWrite(CfgWrite), .CfgIndex(CfgIndex), .CfgField(CfgField), .CfgData(CfgData),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddress(ReqAddress), .ReqWData(ReqWData),
    .RespValid(RespValid), .RespRData(RespRData), .RespError(RespError),
    .TgtValid(TgtValid), .TgtSel(TgtSel), .TgtWrite(TgtWrite),
    .TgtOffset(TgtOffset), .TgtWData(TgtWData),
    .TgtAck(TgtAck), .TgtRData(TgtRData)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  int          got_tv, got_lat;
  logic        got_err, got_wr, got_resp_tgt, stable;
  logic [7:0]  got_rd, got_wd;
  logic [W-1:0] got_sel;
  logic [15:0] got_off;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [1:0] field, input logic [15:0] data);
    CfgWrite = 1'b1; CfgIndex = idx; CfgField = field; CfgData = data;
    tick();
    CfgWrite = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [15:0] addr, input logic [7:0] wd);
    int n = 0;
    while (!ReqReady && n < 20) begin
      tick();
      n++;
    end
    if (!ReqReady) check("ready_bound", 0, 1);
    ReqValid = 1'b1; ReqWrite = wr; ReqAddress = addr; ReqWData = wd;
    tick();
    ReqValid = 1'b0;
  endtask

  // Entered in the DECODE cycle (cycle 1 after the accept cycle); acks are driven in the Nth ACCESS cycle.
  task automatic run_access(input int ack_idx, input int ack_cyc, input logic [7:0] ack_dat,
                            input int stray_idx, input int stray_cyc, input int cfg_cyc);
    bit done = 0;
    got_tv = 0; got_lat = -1; got_err = 0; got_rd = 0; got_sel = '0; got_off = '0;
    got_wr = 0; got_wd = 0; got_resp_tgt = 0; stable = 1;
    TgtRData = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int c = 1; c < 60 && !done; c++) begin
      if (RespValid) begin
        got_lat = c; got_err = RespError; got_rd = RespRData;
        got_resp_tgt = TgtValid | (|TgtSel);
        done = 1;
      end else begin
        if (TgtValid) begin
          got_tv++;
          if (got_tv == 1) begin
            got_sel = TgtSel; got_off = TgtOffset; got_wr = TgtWrite; got_wd = TgtWData;
          end else if (TgtSel !== got_sel || TgtOffset !== got_off ||
                       TgtWrite !== got_wr || TgtWData !== got_wd) begin
            stable = 0;
          end
          if (ack_idx >= 0 && got_tv == ack_cyc) begin
            TgtAck = TgtAck | (4'b1 << ack_idx);
            TgtRData[8*ack_idx +: 8] = ack_dat;
          end
          if (stray_idx >= 0 && got_tv == stray_cyc) TgtAck = TgtAck | (4'b1 << stray_idx);
          if (got_tv == cfg_cyc) begin
            CfgWrite = 1'b1; CfgIndex = 3'd3; CfgField = 2'd2; CfgData = 16'h0000;
          end
        end
        tick();
        TgtAck = '0;
        CfgWrite = 1'b0;
      end
    end
    if (!done) check("resp_bound", 0, 1);
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                        input int ack_idx, input int ack_cyc, input logic [7:0] ack_dat,
                        input int stray_idx, input int stray_cyc, input int cfg_cyc, input bit decode_cfg,
                        input int exp_lat, input logic exp_err, input logic [7:0] exp_rd,
                        input int exp_tv, input logic [W-1:0] exp_sel, input logic [15:0] exp_off);
    issue(wr, addr, wd);
    if (decode_cfg) begin
      CfgWrite = 1'b1; CfgIndex = 3'd3; CfgField = 2'd2; CfgData = 16'h0001;
    end
    run_access(ack_idx, ack_cyc, ack_dat, stray_idx, stray_cyc, cfg_cyc);
    check({tag, ".lat"}, got_lat, exp_lat);
    check({tag, ".err"}, got_err, exp_err);
    check({tag, ".rdata"}, got_rd, exp_rd);
    check({tag, ".tgt_cycles"}, got_tv, exp_tv);
    check({tag, ".tgt_idle_in_resp"}, got_resp_tgt, 0);
    if (exp_tv > 0) begin
      check({tag, ".sel"}, got_sel, exp_sel);
      check({tag, ".offset"}, got_off, exp_off);
      check({tag, ".tgt_write"}, got_wr, wr);
      check({tag, ".tgt_wdata"}, got_wd, wd);
      check({tag, ".held"}, stable, 1);
    end
    tick();
    check({tag, ".one_shot"}, RespValid, 0);
    check({tag, ".ready_after"}, ReqReady, 1);
  endtask

  initial begin
    Reset = 1'b1; CfgWrite = 0; CfgIndex = 0; CfgField = 0; CfgData = 0;
    ReqValid = 0; ReqWrite = 0; ReqAddress = 0; ReqWData = 0;
    TgtAck = '0; TgtRData = '0;
    #2;
    check("rst.req_ready", ReqReady, 0);
    check("rst.resp_valid", RespValid, 0);
    check("rst.resp_error", RespError, 0);
    check("rst.resp_rdata", RespRData, 0);
    check("rst.tgt_valid", TgtValid, 0);
    check("rst.tgt_sel", TgtSel, 0);
    check("rst.tgt_offset", TgtOffset, 0);
    check("rst.tgt_write", TgtWrite, 0);
    check("rst.tgt_wdata", TgtWData, 0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    check("rst.idle_ready", ReqReady, 1);

    do_req("miss0", 0, 16'h1234, 8'h00, -1, 0, 8'h00, -1, 0, 0, 0, 2, 1, 8'hFF, 0, 4'b0000, 16'h0000);

    cfg(3'd1, 2'd0, 16'h2000); cfg(3'd1, 2'd1, 16'h3000); cfg(3'd1, 2'd2, 16'h0001);
    do_req("hit1", 0, 16'h2345, 8'h00, 1, 2, 8'hA5, -1, 0, 0, 0, 4, 0, 8'hA5, 2, 4'b0010, 16'h0345);

    cfg(3'd1, 2'd2, 16'h0000);
    cfg(3'd0, 2'd0, 16'h1000); cfg(3'd0, 2'd1, 16'h2000); cfg(3'd0, 2'd2, 16'h0001);
    cfg(3'd2, 2'd0, 16'h1800); cfg(3'd2, 2'd1, 16'h4000); cfg(3'd2, 2'd2, 16'h0001);
    cfg(3'd3, 2'd0, 16'h5000); cfg(3'd3, 2'd1, 16'h5000); cfg(3'd3, 2'd2, 16'h0001);
    do_req("ovl1800", 0, 16'h1800, 8'h00, 0, 1, 8'h5C, -1, 0, 0, 0, 3, 0, 8'h5C, 1, 4'b0001, 16'h0800);
    do_req("edge1fff", 0, 16'h1FFF, 8'h00, 0, 1, 8'h61, -1, 0, 0, 0, 3, 0, 8'h61, 1, 4'b0001, 16'h0FFF);
    do_req("edge2000", 0, 16'h2000, 8'h00, 2, 1, 8'h22, -1, 0, 0, 0, 3, 0, 8'h22, 1, 4'b0100, 16'h0800);
    do_req("miss4000", 0, 16'h4000, 8'h00, -1, 0, 8'h00, -1, 0, 0, 0, 2, 1, 8'hFF, 0, 4'b0000, 16'h0000);
    do_req("empty5000", 0, 16'h5000, 8'h00, -1, 0, 8'h00, -1, 0, 0, 0, 2, 1, 8'hFF, 0, 4'b0000, 16'h0000);

    cfg(3'd3, 2'd0, 16'h6000); cfg(3'd3, 2'd1, 16'h7000);
    do_req("timeout", 0, 16'h6010, 8'h00, -1, 0, 8'h00, -1, 0, 0, 0, 17, 1, 8'hFF, 15, 4'b1000, 16'h0010);
    do_req("ack_at_15", 0, 16'h6011, 8'h00, 3, 15, 8'h3C, -1, 0, 0, 0, 17, 0, 8'h3C, 15, 4'b1000, 16'h0011);

    do_req("write_stray", 1, 16'h1010, 8'h5A, 0, 3, 8'hEE, 2, 1, 0, 0, 5, 0, 8'h00, 3, 4'b0001, 16'h0010);

    do_req("cfg_in_access", 0, 16'h6020, 8'h00, 3, 3, 8'h77, -1, 0, 1, 0, 5, 0, 8'h77, 3, 4'b1000, 16'h0020);
    do_req("disabled_now", 0, 16'h6020, 8'h00, -1, 0, 8'h00, -1, 0, 0, 0, 2, 1, 8'hFF, 0, 4'b0000, 16'h0000);
    do_req("cfg_in_decode", 0, 16'h6020, 8'h00, -1, 0, 8'h00, -1, 0, 0, 1, 2, 1, 8'hFF, 0, 4'b0000, 16'h0000);
    do_req("enabled_later", 0, 16'h6020, 8'h00, 3, 1, 8'h99, -1, 0, 0, 0, 3, 0, 8'h99, 1, 4'b1000, 16'h0020);

    issue(0, 16'h6030, 8'h00);
    tick();
    check("mid.tgt_valid_before", TgtValid, 1);
    check("mid.tgt_sel_before", TgtSel, 4'b1000);
    #2;
    Reset = 1'b1;
    #1;
    check("mid.tgt_valid_async", TgtValid, 0);
    check("mid.tgt_sel_async", TgtSel, 0);
    check("mid.req_ready_in_reset", ReqReady, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid.no_resp", RespValid, 0);
    end
    Reset = 1'b0;
    #1;
    check("mid.ready_after", ReqReady, 1);
    do_req("post_rst_w0", 0, 16'h1800, 8'h00, -1, 0, 8'h00, -1, 0, 0, 0, 2, 1, 8'hFF, 0, 4'b0000, 16'h0000);
    do_req("post_rst_w3", 0, 16'h6030, 8'h00, -1, 0, 8'h00, -1, 0, 0, 0, 2, 1, 8'hFF, 0, 4'b0000, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/window_bus_controller.md
Name: window_bus_controller

Overview:
- Sequences CPU bus accesses onto up to WINDOWS memory-mapped targets.
- Holds a programmable table of address windows. Each window has a Base, a Head and an Enable bit.
- Decodes each request against the table, forwards a one-hot select plus a window-relative offset (Address - Base), waits for the target's ack, then returns data or an error to the CPU.
- Sits between the CPU core's external bus port and the peripheral/memory blocks.

Parameters:
- WINDOWS, 4, number of windows/targets (1..8).
- TIMEOUT, 15, cycles in ACCESS without ack before the access aborts with an error (1..255).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- CfgWrite  in  1  config write strobe.
- CfgIndex  in  3  window index; writes with CfgIndex >= WINDOWS are ignored.
- CfgField  in  2  field select: 0 = Base, 1 = Head, 2 = Enable (CfgData[0]), 3 = ignored.
- CfgData  in  16  config write data.
- ReqValid  in  1  CPU request present.
- ReqReady  out  1  controller accepts a request this cycle.
- ReqWrite  in  1  1 = write, 0 = read.
- ReqAddress  in  16  CPU address.
- ReqWData  in  8  write data.
- RespValid  out  1  one-cycle response strobe.
- RespRData  out  8  read data; 0xFF on error.
- RespError  out  1  no window matched, or the access timed out.
- TgtValid  out  1  target access in progress.
- TgtSel  out  WINDOWS  one-hot target select.
- TgtWrite  out  1  registered copy of ReqWrite.
- TgtOffset  out  16  ReqAddress - Base, modulo 2^16.
- TgtWData  out  8  registered copy of ReqWData.
- TgtAck  in  WINDOWS  per-target completion.
- TgtRData  in  8*WINDOWS  per-target read data; target i occupies bits [8i+7:8i].

Behaviour:
- Reset state: state = IDLE; all Base = 0, Head = 0, Enable = 0; timeout counter = 0.
- Outputs during/after reset: ReqReady = 0 while Reset is asserted, 1 once in IDLE; RespValid, RespError, TgtValid = 0; TgtSel = 0; RespRData = 0; TgtOffset = 0; TgtWrite = 0; TgtWData = 0.
- Reset asserted mid-access: TgtValid and TgtSel drop immediately (asynchronously), and no response is issued.
- IDLE:
  - ReqReady = 1.
  - ReqValid = 1 latches ReqWrite, ReqAddress and ReqWData, then goes to DECODE.
- DECODE (one cycle, ReqReady = 0):
  - Window i matches iff Enable[i] = 1 and Base[i] <= Addr < Head[i], unsigned.
  - Base >= Head gives an empty window that never matches.
  - If several windows match, the lowest index wins.
  - Match: register TgtSel and TgtOffset = Addr - Base[sel], clear the counter, go to ACCESS.
  - No match: go to RESPOND with error.
- ACCESS:
  - TgtValid = 1; TgtSel, TgtOffset, TgtWrite and TgtWData are held stable.
  - TgtAck[sel] = 1: capture the selected target's read data (0x00 for writes), go to RESPOND with no error.
  - Otherwise the counter increments; reaching TIMEOUT goes to RESPOND with error.
  - If ack and timeout occur in the same cycle, the ack wins.
  - Acks from non-selected targets are ignored.
- RESPOND:
  - RespValid = 1 for exactly one cycle. RespError and RespRData are valid in that cycle; RespRData = 0xFF when RespError = 1.
  - TgtValid = 0, TgtSel = 0.
  - Next state is IDLE, and ReqReady = 1 the cycle after.
- RespValid has no back-pressure.
- Latency: on a hit with the ack in the first ACCESS cycle, RespValid is asserted 3 cycles after the accept edge. A miss takes 2 cycles.
- Config writes:
  - Accepted in any state and take effect on the next edge.
  - A request already past DECODE uses its registered select and offset; a later config write does not disturb it.
  - A config write in the same cycle as DECODE is not seen by that decode.
- Offset arithmetic is 16-bit and wraps; Head = 0xFFFF makes 0xFFFF itself unreachable.

Test Plan:
- Post-reset miss: reset, then read 0x1234 → RespValid 2 cycles after accept, RespError = 1, RespRData = 0xFF; TgtValid never asserted.
- Hit read: window 1 Base = 0x2000, Head = 0x3000, En = 1; read 0x2345, target 1 acks on the 2nd ACCESS cycle with 0xA5 → TgtSel = 0010, TgtOffset = 0x0345, RespRData = 0xA5, RespError = 0.
- Overlap/boundary: window 0 = [0x1000, 0x2000), window 2 = [0x1800, 0x4000), both enabled; 0x1800 → TgtSel = 0001; 0x2000 → TgtSel = 0100, offset 0x0800; 0x4000 → miss; a window with Base = Head = 0x5000 never matches.
- Timeout: TIMEOUT = 15, hit on window 3 with no ack → TgtValid high for exactly 15 cycles, then RespError = 1. Repeat with the ack arriving on cycle 15 → success.
- Write path and stray ack: write 0x5A to window 0 offset 0x0010; target 2 acks first (ignored), then target 0 acks → TgtWrite = 1, TgtWData = 0x5A, RespRData = 0x00, RespError = 0.
- Reset mid-ACCESS and config during access: a CfgWrite disabling the active window during ACCESS does not abort the access. Reset asserted in ACCESS → TgtValid = 0 with no clock edge, no RespValid, and all windows disabled afterwards.
